// File: rtl/fs_block_fetch_pkg.sv
// Shared definitions for the coefficient block fetch/write path.
// Holds the fetch FSM state type, the plane segment type, the SRAM plane
// base addresses and the per-plane last block column, so that the block
// fetcher and the block writer walk the frame identically.
package fs_block_fetch_pkg;

  typedef enum logic [1:0] {
    S_FS_IDLE,
    S_FS_ISSUE,
    S_FS_DRAIN,
    S_FS_DONE
  } FS_state_type;

  typedef enum logic [1:0] {
    SEG_Y,
    SEG_U,
    SEG_V
  } segment_type;

  // SRAM word addresses of the coefficient planes
  localparam logic [17:0] FS_Y_BASE = 18'd76800;
  localparam logic [17:0] FS_U_BASE = 18'd153600;
  localparam logic [17:0] FS_V_BASE = 18'd192000;

  // Last block column / row index per plane
  localparam logic [5:0] FS_Y_C_END  = 6'd39;
  localparam logic [5:0] FS_UV_C_END = 6'd19;
  localparam logic [4:0] FS_R_END    = 5'd29;

  function automatic logic [5:0] fs_c_end(input segment_type seg);
    return (seg == SEG_Y) ? FS_Y_C_END : FS_UV_C_END;
  endfunction

endpackage

// File: rtl/fs_block_fetch_addr_gen.sv
// fs_addr_gen: combinational SRAM address for one coefficient of a block.
//   seg_i  : plane (Y/U/V)
//   rb_i   : block row 0..29
//   cb_i   : block column 0..39 (Y) / 0..19 (U,V)
//   r_i    : row within block 0..7
//   c_i    : column within block 0..7
//   addr_o : base + W*(8*rb + r) + 8*cb + c, W = 320 (Y) or 160 (U,V)
module fs_addr_gen
  import fs_block_fetch_pkg::*;
#(
  parameter logic [17:0] Y_BASE = FS_Y_BASE,
  parameter logic [17:0] U_BASE = FS_U_BASE,
  parameter logic [17:0] V_BASE = FS_V_BASE
) (
  input  segment_type  seg_i,
  input  logic [4:0]   rb_i,
  input  logic [5:0]   cb_i,
  input  logic [2:0]   r_i,
  input  logic [2:0]   c_i,
  output logic [17:0]  addr_o
);

  logic [17:0] row;
  logic [17:0] col;
  logic [17:0] row_off;
  logic [17:0] base;

  always_comb begin
    row     = {10'd0, rb_i, r_i};
    col     = {9'd0, cb_i, c_i};
    row_off = '0;
    base    = Y_BASE;
    case (seg_i)
      SEG_Y: begin
        // 320 = 256 + 64
        row_off = (row << 8) + (row << 6);
        base    = Y_BASE;
      end
      SEG_U: begin
        // 160 = 128 + 32
        row_off = (row << 7) + (row << 5);
        base    = U_BASE;
      end
      default: begin
        row_off = (row << 7) + (row << 5);
        base    = V_BASE;
      end
    endcase
    addr_o = base + row_off + col;
  end

endmodule

// File: rtl/fs_block_fetch.sv
// fs_block_fetch: fetches one 8x8 block of 16-bit pre-IDCT coefficients from
// SRAM per FS_start pulse and writes them, sign-extended to 32 bits, into the
// IDCT dual-port RAM at addresses 0..63. Blocks are walked Y (40x30), U (20x30),
// V (20x30), then back to Y.
// Ports:
//   CLOCK_50_I, Resetn (async, active-low)
//   FS_start        : one-cycle start pulse, only honoured while idle
//   FS_done         : one-cycle pulse once the block is in DP-RAM
//   FS_frame_done   : pulses with FS_done after the last V block
//   SRAM_address    : registered read address, holds while idle
//   SRAM_we_n       : tied high
//   SRAM_read_data  : coefficient, valid SRAM_LAT cycles after the address
//   dp_address / dp_write_data / dp_write_enable : DP-RAM write port
module fs_block_fetch
  import fs_block_fetch_pkg::*;
#(
  parameter logic [17:0] Y_BASE   = FS_Y_BASE,
  parameter logic [17:0] U_BASE   = FS_U_BASE,
  parameter logic [17:0] V_BASE   = FS_V_BASE,
  parameter int unsigned SRAM_LAT = 2
) (
  input  logic         CLOCK_50_I,
  input  logic         Resetn,
  input  logic         FS_start,
  output logic         FS_done,
  output logic         FS_frame_done,
  output logic [17:0]  SRAM_address,
  output logic         SRAM_we_n,
  input  logic [15:0]  SRAM_read_data,
  output logic [6:0]   dp_address,
  output logic [31:0]  dp_write_data,
  output logic         dp_write_enable
);

  FS_state_type        state_q, state_d;
  segment_type         seg_q, seg_d;
  logic [4:0]          rb_q, rb_d;
  logic [5:0]          cb_q, cb_d;
  logic [5:0]          k_q, k_d;
  logic [5:0]          wr_k_q, wr_k_d;
  logic [SRAM_LAT-1:0] vld_q, vld_d;
  logic [17:0]         addr_q, addr_d;
  logic [6:0]          dp_addr_q, dp_addr_d;
  logic [31:0]         dp_data_q, dp_data_d;
  logic                dp_we_q, dp_we_d;
  logic                done_q, done_d;
  logic                frame_q, frame_d;
  logic [17:0]         gen_addr;

  fs_addr_gen #(
    .Y_BASE (Y_BASE),
    .U_BASE (U_BASE),
    .V_BASE (V_BASE)
  ) u_addr_gen (
    .seg_i  (seg_q),
    .rb_i   (rb_q),
    .cb_i   (cb_q),
    .r_i    (k_q[5:3]),
    .c_i    (k_q[2:0]),
    .addr_o (gen_addr)
  );

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_FS_IDLE;
      seg_q     <= SEG_Y;
      rb_q      <= '0;
      cb_q      <= '0;
      k_q       <= '0;
      wr_k_q    <= '0;
      vld_q     <= '0;
      addr_q    <= '0;
      dp_addr_q <= '0;
      dp_data_q <= '0;
      dp_we_q   <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      rb_q      <= rb_d;
      cb_q      <= cb_d;
      k_q       <= k_d;
      wr_k_q    <= wr_k_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      dp_addr_q <= dp_addr_d;
      dp_data_q <= dp_data_d;
      dp_we_q   <= dp_we_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    rb_d      = rb_q;
    cb_d      = cb_q;
    k_d       = k_q;
    wr_k_d    = wr_k_q;
    addr_d    = addr_q;
    dp_addr_d = dp_addr_q;
    dp_data_d = dp_data_q;
    dp_we_d   = 1'b0;
    done_d    = 1'b0;
    frame_d   = 1'b0;
    // vld_q[i] marks a read issued i+1 edges ago; the oldest stage lines up
    // with valid SRAM_read_data.
    vld_d     = vld_q << 1;

    // Writes are strictly in issue order, so a running count gives dp_address.
    if (vld_q[SRAM_LAT-1]) begin
      dp_we_d   = 1'b1;
      dp_addr_d = {1'b0, wr_k_q};
      dp_data_d = {{16{SRAM_read_data[15]}}, SRAM_read_data};
      wr_k_d    = wr_k_q + 6'd1;
    end

    case (state_q)
      S_FS_IDLE: begin
        if (FS_start) begin
          state_d = S_FS_ISSUE;
          k_d     = '0;
          wr_k_d  = '0;
        end
      end
      S_FS_ISSUE: begin
        addr_d   = gen_addr;
        vld_d[0] = 1'b1;
        k_d      = k_q + 6'd1;
        if (k_q == 6'd63) begin
          state_d = S_FS_DRAIN;
        end
      end
      S_FS_DRAIN: begin
        if (vld_q[SRAM_LAT-1] && (wr_k_q == 6'd63)) begin
          state_d = S_FS_DONE;
        end
      end
      S_FS_DONE: begin
        done_d  = 1'b1;
        state_d = S_FS_IDLE;
        if (cb_q == fs_c_end(seg_q)) begin
          cb_d = '0;
          if (rb_q == FS_R_END) begin
            rb_d = '0;
            case (seg_q)
              SEG_Y:   seg_d = SEG_U;
              SEG_U:   seg_d = SEG_V;
              default: begin
                seg_d   = SEG_Y;
                frame_d = 1'b1;
              end
            endcase
          end else begin
            rb_d = rb_q + 5'd1;
          end
        end else begin
          cb_d = cb_q + 6'd1;
        end
      end
      default: state_d = S_FS_IDLE;
    endcase
  end

  assign FS_done         = done_q;
  assign FS_frame_done   = frame_q;
  assign SRAM_address    = addr_q;
  assign SRAM_we_n       = 1'b1;
  assign dp_address      = dp_addr_q;
  assign dp_write_data   = dp_data_q;
  assign dp_write_enable = dp_we_q;

endmodule

// File: tb/tb_fs_block_fetch.sv
module tb_fs_block_fetch;
  import fs_block_fetch_pkg::*;

  logic        clk;
  logic        Resetn;
  logic        FS_start;
  logic        FS_done;
  logic        FS_frame_done;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [6:0]  dp_address;
  logic [31:0] dp_write_data;
  logic        dp_write_enable;

  int total = 0;
  int bad   = 0;

  // Block position the bench expects the DUT to fetch next
  segment_type m_seg;
  int          m_rb;
  int          m_cb;

  fs_block_fetch #(
    .Y_BASE   (18'd76800),
    .U_BASE   (18'd153600),
    .V_BASE   (18'd192000),
    .SRAM_LAT (2)
  ) dut (
    .CLOCK_50_I      (clk),
    .Resetn          (Resetn),
    .FS_start        (FS_start),
    .FS_done         (FS_done),
    .FS_frame_done   (FS_frame_done),
    .SRAM_address    (SRAM_address),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data),
    .dp_address      (dp_address),
    .dp_write_data   (dp_write_data),
    .dp_write_enable (dp_write_enable)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Coefficient stored at each SRAM word; two hand-picked sign-boundary values.
  function automatic logic [15:0] data_of(input logic [17:0] a);
    if (a == 18'd76805) return 16'hFF80;
    if (a == 18'd76806) return 16'h007F;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // SRAM with two cycles of latency: address register then data register.
  logic [15:0] sram_q;
  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) sram_q <= 16'h0000;
    else         sram_q <= data_of(SRAM_address);
  end
  assign SRAM_read_data = sram_q;

  function automatic logic [17:0] exp_addr(input int k);
    int base, w, a;
    base = (m_seg == SEG_Y) ? 76800 : (m_seg == SEG_U) ? 153600 : 192000;
    w    = (m_seg == SEG_Y) ? 320 : 160;
    a    = base + w * (8 * m_rb + k / 8) + 8 * m_cb + k % 8;
    return 18'(a);
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  task automatic advance_model();
    int cend;
    cend = (m_seg == SEG_Y) ? 39 : 19;
    if (m_cb == cend) begin
      m_cb = 0;
      if (m_rb == 29) begin
        m_rb = 0;
        m_seg = (m_seg == SEG_Y) ? SEG_U : (m_seg == SEG_U) ? SEG_V : SEG_Y;
      end else begin
        m_rb = m_rb + 1;
      end
    end else begin
      m_cb = m_cb + 1;
    end
  endtask

  // One fetch. Observation after edge E(cyc) is taken on the following negedge.
  task automatic fetch_block(input int pulse_at, input int reset_at, input bit full,
                             output logic [17:0] first_a, output logic [17:0] last_a);
    logic [17:0] ea;
    logic [31:0] ed;
    bit          ef;
    int          k;
    ef = (m_seg == SEG_V) && (m_rb == 29) && (m_cb == 19);
    first_a = '0;
    last_a  = '0;
    @(negedge clk);
    FS_start = 1'b1;
    @(negedge clk);
    FS_start = 1'b0;
    for (int cyc = 1; cyc <= 68; cyc++) begin
      @(negedge clk);
      if (cyc == reset_at) begin
        Resetn = 1'b0;
        #1;
        total++;
        if (dp_write_enable !== 1'b0 || SRAM_address !== 18'd0 || dp_address !== 7'd0 ||
            dp_write_data !== 32'd0 || FS_done !== 1'b0) begin
          bad++;
          $display("FAIL async_reset: we=%b addr=%0d dpa=%0d dpd=%h done=%b, want all zero",
                   dp_write_enable, SRAM_address, dp_address, dp_write_data, FS_done);
        end
        return;
      end
      if (cyc <= 64) begin
        k  = cyc - 1;
        ea = exp_addr(k);
        if (cyc == 1)  first_a = SRAM_address;
        if (cyc == 64) last_a  = SRAM_address;
        if (full || k == 0 || k == 63) begin
          total++;
          if (SRAM_address !== ea) begin
            bad++;
            $display("FAIL sram_addr k=%0d: got %0d want %0d", k, SRAM_address, ea);
          end
        end
      end else if (full) begin
        total++;
        if (SRAM_address !== exp_addr(63)) begin
          bad++;
          $display("FAIL addr_hold cyc=%0d: got %0d want %0d", cyc, SRAM_address, exp_addr(63));
        end
      end
      if (cyc >= 3 && cyc <= 66) begin
        k  = cyc - 3;
        ed = sext(data_of(exp_addr(k)));
        total++;
        if (dp_write_enable !== 1'b1 || (full && (dp_address !== 7'(k) || dp_write_data !== ed))) begin
          bad++;
          $display("FAIL dp_write k=%0d: we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                   k, dp_write_enable, dp_address, dp_write_data, k, ed);
        end
      end else begin
        total++;
        if (dp_write_enable !== 1'b0) begin
          bad++;
          $display("FAIL dp_we_idle cyc=%0d: got %b want 0", cyc, dp_write_enable);
        end
      end
      total++;
      if (cyc == 67) begin
        if (FS_done !== 1'b1 || FS_frame_done !== ef) begin
          bad++;
          $display("FAIL done_pulse: done=%b frame=%b want done=1 frame=%b", FS_done, FS_frame_done, ef);
        end
      end else if (FS_done !== 1'b0 || FS_frame_done !== 1'b0) begin
        bad++;
        $display("FAIL done_low cyc=%0d: done=%b frame=%b want 0 0", cyc, FS_done, FS_frame_done);
      end
      FS_start = (cyc == pulse_at);
    end
    FS_start = 1'b0;
    advance_model();
  endtask

  // Places the DUT's block position directly so the plane boundaries are reachable.
  task automatic preset(input segment_type s, input int rb, input int cb);
    logic [4:0] rb_v;
    logic [5:0] cb_v;
    rb_v = 5'(rb);
    cb_v = 6'(cb);
    @(negedge clk);
    force dut.seg_q = s;
    force dut.rb_q  = rb_v;
    force dut.cb_q  = cb_v;
    @(negedge clk);
    release dut.seg_q;
    release dut.rb_q;
    release dut.cb_q;
    m_seg = s;
    m_rb  = rb;
    m_cb  = cb;
  endtask

  task automatic test_reset();
    Resetn   = 1'b0;
    FS_start = 1'b0;
    m_seg = SEG_Y; m_rb = 0; m_cb = 0;
    repeat (3) @(negedge clk);
    total++;
    if (FS_done !== 1'b0 || FS_frame_done !== 1'b0 || SRAM_address !== 18'd0 || SRAM_we_n !== 1'b1 ||
        dp_address !== 7'd0 || dp_write_data !== 32'd0 || dp_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: done=%b frame=%b addr=%0d we_n=%b dpa=%0d dpd=%h dpwe=%b",
               FS_done, FS_frame_done, SRAM_address, SRAM_we_n, dp_address, dp_write_data, dp_write_enable);
    end
    Resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_block();
    logic [17:0] fa, la;
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (fa !== 18'd76800 || la !== 18'd79047) begin
      bad++;
      $display("FAIL first_block_span: got %0d..%0d want 76800..79047", fa, la);
    end
    total++;
    if (sext(data_of(18'd76805)) !== 32'hFFFFFF80 || sext(data_of(18'd76806)) !== 32'h0000007F) begin
      bad++;
      $display("FAIL sign_ext_vectors: got %h %h want FFFFFF80 0000007F",
               sext(data_of(18'd76805)), sext(data_of(18'd76806)));
    end
  endtask

  task automatic test_row_advance();
    logic [17:0] fa, la;
    for (int b = 1; b < 40; b++) fetch_block(0, 0, 1'b0, fa, la);
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (fa !== 18'd79360) begin
      bad++;
      $display("FAIL row_advance: got %0d want 79360", fa);
    end
  endtask

  task automatic test_seg_boundaries();
    logic [17:0] fa, la;
    preset(SEG_Y, 29, 39);
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (la !== 18'd153599) begin
      bad++;
      $display("FAIL y_last: got %0d want 153599", la);
    end
    fetch_block(0, 0, 1'b0, fa, la);
    total++;
    if (fa !== 18'd153600) begin
      bad++;
      $display("FAIL u_first: got %0d want 153600", fa);
    end
    preset(SEG_U, 29, 19);
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (la !== 18'd191999) begin
      bad++;
      $display("FAIL u_last: got %0d want 191999", la);
    end
    fetch_block(0, 0, 1'b0, fa, la);
    total++;
    if (fa !== 18'd192000) begin
      bad++;
      $display("FAIL v_first: got %0d want 192000", fa);
    end
  endtask

  task automatic test_frame_wrap();
    logic [17:0] fa, la;
    preset(SEG_V, 29, 19);
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (la !== 18'd230399) begin
      bad++;
      $display("FAIL v_last: got %0d want 230399", la);
    end
    fetch_block(0, 0, 1'b0, fa, la);
    total++;
    if (fa !== 18'd76800) begin
      bad++;
      $display("FAIL wrap_first: got %0d want 76800", fa);
    end
  endtask

  task automatic test_start_ignored();
    logic [17:0] fa, la;
    int extra_done;
    fetch_block(20, 0, 1'b1, fa, la);
    extra_done = 0;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      if (FS_done === 1'b1 || dp_write_enable === 1'b1) extra_done++;
    end
    total++;
    if (extra_done !== 0) begin
      bad++;
      $display("FAIL start_ignored: got %0d extra active cycles want 0", extra_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] fa, la;
    fetch_block(0, 30, 1'b0, fa, la);
    @(negedge clk);
    Resetn = 1'b1;
    m_seg = SEG_Y; m_rb = 0; m_cb = 0;
    fetch_block(0, 0, 1'b1, fa, la);
    total++;
    if (fa !== 18'd76800) begin
      bad++;
      $display("FAIL after_reset_first: got %0d want 76800", fa);
    end
  endtask

  initial begin
    Resetn   = 1'b0;
    FS_start = 1'b0;
    test_reset();
    test_first_block();
    test_row_advance();
    test_seg_boundaries();
    test_frame_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fs_block_fetch.md
# fs_block_fetch

Fetches one 8×8 block of 16-bit pre-IDCT coefficients (S′) per start pulse from external SRAM and writes them into the embedded dual-port RAM that feeds the IDCT datapath. It is the read-side counterpart of the block writer that drains clipped pixels back to SRAM. It walks the coefficient frame in block order: Y (40×30 blocks), then U (20×30), then V (20×30), then wraps to Y. It is started and monitored by the milestone-2 top-level FSM.

## Interface
Parameters:
- Y_BASE, 76800: SRAM word address of Y coefficient plane (320 coeffs/row).
- U_BASE, 153600: SRAM word address of U plane (160 coeffs/row).
- V_BASE, 192000: SRAM word address of V plane (160 coeffs/row).
- SRAM_LAT, 2: cycles from SRAM_address change to valid SRAM_read_data.

Ports:
- CLOCK_50_I  in  1  50 MHz clock.
- Resetn  in  1  reset, asynchronous, active-low.
- FS_start  in  1  one-cycle pulse; fetch next block.
- FS_done  out  1  one-cycle pulse; block fully written to DP-RAM.
- FS_frame_done  out  1  pulses with FS_done when the block just fetched was the last V block.
- SRAM_address  out  18  registered read address.
- SRAM_we_n  out  1  constant 1 (read only).
- SRAM_read_data  in  16  coefficient, two's complement.
- dp_address  out  7  DP-RAM write address, 0..63.
- dp_write_data  out  32  sign-extended coefficient.
- dp_write_enable  out  1  DP-RAM write strobe.

## Operation
- Reset values: FS_done=0, FS_frame_done=0, SRAM_address=0, SRAM_we_n=1, dp_address=0, dp_write_data=0, dp_write_enable=0. Internal state: state=S_FS_IDLE, block column CB=0, block row RB=0, segment=Y, element counter=0.
- States:
  - S_FS_IDLE: wait for FS_start. FS_start is ignored in any other state.
  - S_FS_ISSUE: present 64 read addresses, one per cycle.
  - S_FS_DRAIN: collect the final SRAM_LAT reads.
  - S_FS_DONE: pulse done, advance block position, return to IDLE.
- Element index k = 8r + c (r, c in 0..7), issued in row-major order.
- Address: SRAM_address = base + W·(8·RB + r) + 8·CB + c.
  - Y: W = 320, computed as (row<<8) + (row<<6).
  - U/V: W = 160, computed as (row<<7) + (row<<5).
  - All arithmetic is 18-bit. The maximum address is 230399, so no overflow.
- Write: element k is written to dp_address=k with dp_write_data = {{16{d[15]}}, d}.
- Block advance, applied in S_FS_DONE:
  - CB increments until C_END. C_END is 39 for Y and 19 for U/V.
  - At C_END, CB resets to 0 and RB increments.
  - At RB=29 and CB=C_END, RB resets to 0 and segment advances Y→U→V→Y.
  - On V→Y, FS_frame_done=1 for that same cycle.
- Reset mid-block: all outputs and counters return to their reset values immediately. The partially written DP-RAM contents are don't-care.

## Timing
Edge E0 is the edge that samples FS_start=1.
- SRAM_address takes the element-k address at edge E(1+k), for k=0..63.
- Element k data is sampled at edge E(1+k+SRAM_LAT). At that edge the module registers dp_address=k, dp_write_data, and dp_write_enable=1.
- dp_write_enable is high for 64 consecutive cycles, with no gaps.
- At E(65+SRAM_LAT): dp_write_enable=0, FS_done=1, state=S_FS_IDLE.
- At the next edge FS_done returns to 0.
- Start-to-done latency with SRAM_LAT=2 is 67 cycles.
- FS_start may be reasserted in the cycle after FS_done. Minimum block period is 68 cycles.
- SRAM_address holds its last value while idle.

## Structure
- Shared package holds:
  - FS_state_type enum (S_FS_IDLE, S_FS_ISSUE, S_FS_DRAIN, S_FS_DONE).
  - Segment enum (SEG_Y, SEG_U, SEG_V).
  - Base-address and C_END constants, so the block writer uses the same values.
- One combinational sub-module, fs_addr_gen: inputs segment, RB, CB, r, c; output 18-bit SRAM address.

## Test plan
- Reset, then one FS_start → SRAM addresses 76800..76807, then 77120..77127, through 79047. dp_address runs 0..63. FS_done rises 67 cycles after the start edge.
- SRAM returns 16'hFF80 at k=5 and 16'h007F at k=6 → dp_write_data equals 32'hFFFFFF80 and 32'h0000007F at dp_address 5 and 6.
- Issue 40 starts → 41st block's first address is 79360 (RB=1, CB=0, Y).
- Run through Y block (29,39), whose last address is 153599 → next block's first address is 153600 (U). After U block (29,19), ending at 191999, the next block starts at 192000 (V).
- Final V block, ending at 230399 → FS_frame_done=1 together with FS_done. Next start fetches from 76800.
- FS_start pulsed at cycle 20 of a fetch → ignored, one FS_done only. Resetn low at cycle 30 → dp_write_enable=0 immediately. The next start fetches from 76800.
